// File: rtl/piso_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : piso_serializer                                               |
// | Brief    : Captures a WIDTH-bit word over valid/ready and emits it one   |
// |            bit per accepted beat. Define SER_PARITY_EN to append an      |
// |            even-parity beat after the data bits.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             busy,
    output logic             done
);

    localparam int c_cnt_w = $clog2(WIDTH + 2);
`ifdef SER_PARITY_EN
    localparam int c_nbits = WIDTH + 1;
`else
    localparam int c_nbits = WIDTH;
`endif
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_nbits);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_sreg;
    logic [WIDTH-1:0]     w_sreg_next;
    logic [WIDTH-1:0]     w_sreg_shifted;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic                 w_end_bit;
    logic                 w_emit_bit;

    // The emitted end of the register and the zero-filled shift toward it.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_end_bit      = r_sreg[0];
            assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_end_bit      = r_sreg[WIDTH-1];
            assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
        end
    endgenerate

`ifdef SER_PARITY_EN
    logic r_parity;

    // The final beat (cnt==1) carries the parity captured at load time.
    assign w_emit_bit = (r_cnt == c_cnt_one) ? r_parity : w_end_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_parity <= ^in_data;
        end
    end
`else
    assign w_emit_bit = w_end_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_sreg  <= w_sreg_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Outputs depend on registered state only; inputs steer next-state alone.
    always_comb begin
        w_state_next = r_state;
        w_sreg_next  = r_sreg;
        w_cnt_next   = r_cnt;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_bit      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_sreg_next  = in_data;
                    w_cnt_next   = c_cnt_load;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_bit   = w_emit_bit;
                if (out_ready) begin
                    w_sreg_next = w_sreg_shifted;
                    w_cnt_next  = r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done         = 1'b1;
                busy         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_piso_serializer                                            |
// | Brief    : Bench for piso_serializer, LSB-first and MSB-first instances  |
// |            driven in lockstep against a bit-index reference model.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_piso_serializer;

    localparam int W = 4;
`ifdef SER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic in_ready_l, out_valid_l, out_bit_l, busy_l, done_l;
    logic in_ready_m, out_valid_m, out_bit_m, busy_m, done_m;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_bit(out_bit_l),
        .busy(busy_l), .done(done_l)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_bit(out_bit_m),
        .busy(busy_m), .done(done_m)
    );

    // Reference: beat i carries data bit i (LSB first) or bit W-1-i (MSB
    // first); beat W, when present, carries the even parity of the word.
    function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit msb);
        if (i >= W) return ^w;
        return msb ? w[W-1-i] : w[i];
    endfunction

    function automatic logic [7:0] status();
        return {in_ready_l, out_valid_l, busy_l, done_l,
                in_ready_m, out_valid_m, busy_m, done_m};
    endfunction

    // mode 0: out_ready always 1; 1: random; 2: fixed 1,0,0,1,1,1 then 1s
    task automatic run_word(input logic [W-1:0] w, input int mode, input bit junk,
                            input string tag);
        int beat = 0;
        int cyc = 0;
        logic rdy;
        logic [15:0] pat = 16'hFFF9;
        @(negedge clk);
        vectors++;
        if (status() !== 8'b1000_1000) begin
            miscompares++;
            $display("FAIL %s idle_status: got %b expected %b", tag, status(), 8'b1000_1000);
        end
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'($urandom_range(0, 1));
        while (beat < NB) begin
            @(negedge clk);
            if (junk) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            vectors++;
            if (status() !== 8'b0110_0110) begin
                miscompares++;
                $display("FAIL %s shift_status beat %0d: got %b expected %b",
                         tag, beat, status(), 8'b0110_0110);
            end
            vectors++;
            if (out_bit_l !== exp_bit(w, beat, 1'b0) || out_bit_m !== exp_bit(w, beat, 1'b1)) begin
                miscompares++;
                $display("FAIL %s out_bit beat %0d: got lsb=%b msb=%b expected lsb=%b msb=%b",
                         tag, beat, out_bit_l, out_bit_m,
                         exp_bit(w, beat, 1'b0), exp_bit(w, beat, 1'b1));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc < 16) ? pat[cyc] : 1'b1;
            endcase
            out_ready = rdy;
            if (rdy) beat++;
            cyc++;
            if (cyc > 200) begin
                miscompares++;
                $display("FAIL %s timeout: got %0d beats expected %0d", tag, beat, NB);
                break;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        vectors++;
        if (status() !== 8'b0011_0011) begin
            miscompares++;
            $display("FAIL %s done_status: got %b expected %b", tag, status(), 8'b0011_0011);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = W'($urandom);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({status(), out_bit_l, out_bit_m} !== 10'b1000_1000_00) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b",
                     {status(), out_bit_l, out_bit_m}, 10'b1000_1000_00);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_directed();
        run_word(4'b1011, 0, 1'b0, "basic_1011");
        run_word(4'b0011, 0, 1'b0, "basic_0011");
    endtask

    task automatic test_stall();
        run_word(4'b0110, 2, 1'b0, "stall_0110");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            vectors++;
            if (out_valid_l !== 1'b1 || out_bit_l !== 1'b1 || out_bit_m !== 1'b1) begin
                miscompares++;
                $display("FAIL midrst_prefix beat %0d: got valid=%b lsb=%b msb=%b expected 1 1 1",
                         i, out_valid_l, out_bit_l, out_bit_m);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({status(), out_bit_l, out_bit_m} !== 10'b1000_1000_00) begin
            miscompares++;
            $display("FAIL midrst_state: got %b expected %b",
                     {status(), out_bit_l, out_bit_m}, 10'b1000_1000_00);
        end
        rst = 1'b0;
        run_word(4'b0001, 0, 1'b0, "after_rst_0001");
    endtask

    task automatic test_ignored_input();
        run_word(4'b1011, 0, 1'b1, "ignored_busy");
        run_word(4'b0000, 1, 1'b1, "next_0000");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_word(W'($urandom), 0, 1'b0, "b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_word(W'($urandom), 1, 1'($urandom_range(0, 1)), "random");
        @(negedge clk);
        vectors++;
        if (status() !== 8'b1000_1000) begin
            miscompares++;
            $display("FAIL final_idle: got %b expected %b", status(), 8'b1000_1000);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid();
        test_ignored_input();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
